// File: rtl/seq_detector_param_if.sv
// Port bundle for the parameterised serial-pattern detector.
// en qualifies din for one cycle; there is no backpressure, every qualified sample is consumed.
interface seq_detector_param_if #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
);
  logic               en;
  logic               din;
  logic               pat_load;
  logic [PAT_LEN-1:0] pat_in;
  logic               cnt_clr;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic [4:0]         progress;

  modport master (
    output en, din, pat_load, pat_in, cnt_clr,
    input  match, match_cnt, progress
  );

  modport slave (
    input  en, din, pat_load, pat_in, cnt_clr,
    output match, match_cnt, progress
  );
endinterface

// File: rtl/seq_detector_param.sv
// Moore detector for a runtime-loaded PAT_LEN-bit pattern on a serial stream,
// with overlap control, sample enable and a saturating match counter.
module seq_detector_param #(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8,
  parameter int OVERLAP = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  seq_detector_param_if.slave  bus
);

  localparam logic [4:0]       FULL    = 5'(PAT_LEN);
  localparam logic [4:0]       HMAX    = 5'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [4:0]         state, state_nxt;
  logic [PAT_LEN-1:0] pattern, pattern_nxt;
  // Only the previous PAT_LEN-1 samples are kept; the incoming bit completes the window.
  logic [PAT_LEN-2:0] hist, hist_nxt;
  logic [4:0]         hlen, hlen_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [PAT_LEN-1:0] cand, mask;
  logic [4:0]         cand_len;
  logic               accept;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= '0;
      pattern <= '0;
      hist    <= '0;
      hlen    <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      pattern <= pattern_nxt;
      hist    <= hist_nxt;
      hlen    <= hlen_nxt;
      cnt     <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pattern_nxt = pattern;
    hist_nxt    = hist;
    hlen_nxt    = hlen;
    cnt_nxt     = cnt;
    accept      = 1'b0;
    mask        = '0;
    cand        = {hist, bus.din};
    cand_len    = hlen + 5'd1;
    if (OVERLAP == 0 && state == FULL) begin
      cand     = {{(PAT_LEN-1){1'b0}}, bus.din};
      cand_len = 5'd1;
    end

    if (bus.pat_load) begin
      pattern_nxt = bus.pat_in;
      hist_nxt    = '0;
      hlen_nxt    = '0;
      state_nxt   = '0;
    end else if (bus.en) begin
      hist_nxt  = cand[PAT_LEN-2:0];
      hlen_nxt  = (cand_len > HMAX) ? HMAX : cand_len;
      state_nxt = '0;
      // Ascending scan: the longest window suffix equal to a pattern prefix wins.
      for (int k = 1; k <= PAT_LEN; k++) begin
        mask = {PAT_LEN{1'b1}} >> (PAT_LEN - k);
        if (5'(k) <= cand_len && (cand & mask) == ((pattern >> (PAT_LEN - k)) & mask))
          state_nxt = 5'(k);
      end
      accept = (state_nxt == FULL);
    end

    if (bus.cnt_clr)
      cnt_nxt = '0;
    else if (accept && cnt != CNT_MAX)
      cnt_nxt = cnt + 1'b1;
  end

  assign bus.match     = (state == FULL);
  assign bus.match_cnt = cnt;
  assign bus.progress  = state;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three configurations driven from directed tables,
// hand-written corner sequences and random traffic against a history-window model.
module tb_seq_detector_param;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) ifa ();
  seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) ifb ();
  seq_detector_param_if #(.PAT_LEN(2), .CNT_W(2)) ifc ();

  assign ifb.en       = ifa.en;
  assign ifb.din      = ifa.din;
  assign ifb.pat_load = ifa.pat_load;
  assign ifb.pat_in   = ifa.pat_in;
  assign ifb.cnt_clr  = ifa.cnt_clr;

  seq_detector_param #(.PAT_LEN(4), .CNT_W(8), .OVERLAP(1)) dut_a (.CLK(CLK), .RST(RST), .bus(ifa.slave));
  seq_detector_param #(.PAT_LEN(4), .CNT_W(8), .OVERLAP(0)) dut_b (.CLK(CLK), .RST(RST), .bus(ifb.slave));
  seq_detector_param #(.PAT_LEN(2), .CNT_W(2), .OVERLAP(1)) dut_c (.CLK(CLK), .RST(RST), .bus(ifc.slave));

  int checks   = 0;
  int failures = 0;

  // Reference model: explicit list of valid samples per configuration.
  int cfg_len [3] = '{4, 4, 2};
  int cfg_ovl [3] = '{1, 0, 1};
  int cfg_max [3] = '{255, 255, 3};
  int m_hist  [3][16];
  int m_hlen  [3];
  int m_pat   [3];
  int m_st    [3];
  int m_cnt   [3];

  typedef struct {
    int din;
    int ma, ca, pa;
    int mb, cb, pb;
  } vec_t;
  vec_t t1 [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int longest(input int c);
    int len = cfg_len[c];
    for (int k = len; k >= 1; k--) begin
      if (k <= m_hlen[c]) begin
        bit ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (m_hist[c][m_hlen[c] - k + i] != ((m_pat[c] >> (len - 1 - i)) & 1)) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_hlen[c] = 0; m_pat[c] = 0; m_st[c] = 0; m_cnt[c] = 0;
    end
  endtask

  task automatic model_step(input int c, input int en, input int din, input int load,
                            input int pat, input int clr);
    bit acc = 1'b0;
    int len = cfg_len[c];
    if (load != 0) begin
      m_pat[c] = pat; m_hlen[c] = 0; m_st[c] = 0;
    end else if (en != 0) begin
      if (cfg_ovl[c] == 0 && m_st[c] == len) m_hlen[c] = 0;
      if (m_hlen[c] == len) begin
        for (int i = 0; i < len - 1; i++) m_hist[c][i] = m_hist[c][i+1];
        m_hlen[c] = len - 1;
      end
      m_hist[c][m_hlen[c]] = din;
      m_hlen[c]++;
      m_st[c] = longest(c);
      acc = (m_st[c] == len);
    end
    if (clr != 0) m_cnt[c] = 0;
    else if (acc && m_cnt[c] < cfg_max[c]) m_cnt[c]++;
  endtask

  task automatic check_all();
    chk("a_match", int'(ifa.match),     int'(m_st[0] == 4));
    chk("a_cnt",   int'(ifa.match_cnt), m_cnt[0]);
    chk("a_prog",  int'(ifa.progress),  m_st[0]);
    chk("b_match", int'(ifb.match),     int'(m_st[1] == 4));
    chk("b_cnt",   int'(ifb.match_cnt), m_cnt[1]);
    chk("b_prog",  int'(ifb.progress),  m_st[1]);
    chk("c_match", int'(ifc.match),     int'(m_st[2] == 2));
    chk("c_cnt",   int'(ifc.match_cnt), m_cnt[2]);
    chk("c_prog",  int'(ifc.progress),  m_st[2]);
  endtask

  task automatic drive_ab(input int en, input int din, input int load, input int pat, input int clr);
    ifa.en = 1'(en); ifa.din = 1'(din); ifa.pat_load = 1'(load);
    ifa.pat_in = 4'(pat); ifa.cnt_clr = 1'(clr);
  endtask

  task automatic drive_c(input int en, input int din, input int load, input int pat, input int clr);
    ifc.en = 1'(en); ifc.din = 1'(din); ifc.pat_load = 1'(load);
    ifc.pat_in = 2'(pat); ifc.cnt_clr = 1'(clr);
  endtask

  // Advance one edge, update the model with the inputs seen at that edge, check #1 later.
  task automatic tick();
    @(posedge CLK);
    model_step(0, int'(ifa.en), int'(ifa.din), int'(ifa.pat_load), int'(ifa.pat_in), int'(ifa.cnt_clr));
    model_step(1, int'(ifa.en), int'(ifa.din), int'(ifa.pat_load), int'(ifa.pat_in), int'(ifa.cnt_clr));
    model_step(2, int'(ifc.en), int'(ifc.din), int'(ifc.pat_load), int'(ifc.pat_in), int'(ifc.cnt_clr));
    #1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t3_pa [6] = '{1, 2, 3, 4, 4, 4};
    int t3_pb [6] = '{1, 2, 3, 4, 1, 2};
    int t4_bits [4] = '{1, 0, 1, 1};
    int t6_cnt [5] = '{1, 2, 3, 3, 3};

    t1[0] = '{1, 0, 0, 1, 0, 0, 1};
    t1[1] = '{0, 0, 0, 2, 0, 0, 2};
    t1[2] = '{1, 0, 0, 3, 0, 0, 3};
    t1[3] = '{1, 1, 1, 4, 1, 1, 4};
    t1[4] = '{0, 0, 1, 2, 0, 1, 0};
    t1[5] = '{1, 0, 1, 3, 0, 1, 1};
    t1[6] = '{1, 1, 2, 4, 0, 1, 1};

    drive_ab(0, 0, 0, 0, 0);
    drive_c(0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("rst_match", int'(ifa.match), 0);
    chk("rst_cnt",   int'(ifa.match_cnt), 0);
    chk("rst_prog",  int'(ifa.progress), 0);
    chk("rst_c_cnt", int'(ifc.match_cnt), 0);
    RST = 1'b1;

    // T1/T2: pattern 1011, overlapping (a) versus flushing (b)
    drive_ab(0, 0, 1, 4'b1011, 1); tick();
    for (int i = 0; i < 7; i++) begin
      drive_ab(1, t1[i].din, 0, 0, 0); tick();
      chk("t1_match", int'(ifa.match),     t1[i].ma);
      chk("t1_cnt",   int'(ifa.match_cnt), t1[i].ca);
      chk("t1_prog",  int'(ifa.progress),  t1[i].pa);
      chk("t2_match", int'(ifb.match),     t1[i].mb);
      chk("t2_cnt",   int'(ifb.match_cnt), t1[i].cb);
      chk("t2_prog",  int'(ifb.progress),  t1[i].pb);
    end

    // T3: pattern 1111, six ones
    drive_ab(0, 0, 1, 4'b1111, 1); tick();
    for (int i = 0; i < 6; i++) begin
      drive_ab(1, 1, 0, 0, 0); tick();
      chk("t3_prog_a", int'(ifa.progress), t3_pa[i]);
      chk("t3_prog_b", int'(ifb.progress), t3_pb[i]);
      chk("t3_match_a", int'(ifa.match), int'(i >= 3));
    end
    chk("t3_cnt_a", int'(ifa.match_cnt), 3);
    chk("t3_cnt_b", int'(ifb.match_cnt), 1);

    // T4: idle gaps between samples
    drive_ab(0, 0, 1, 4'b1011, 1); tick();
    for (int i = 0; i < 4; i++) begin
      drive_ab(1, t4_bits[i], 0, 0, 0); tick();
      chk("t4_prog", int'(ifa.progress), i + 1);
      for (int j = 0; j < 2; j++) begin
        drive_ab(0, $urandom_range(0, 1), 0, 0, 0); tick();
        chk("t4_hold", int'(ifa.progress), i + 1);
        chk("t4_match_hold", int'(ifa.match), int'(i == 3));
      end
    end
    chk("t4_cnt", int'(ifa.match_cnt), 1);
    drive_ab(1, 0, 0, 0, 0); tick();
    chk("t4_match_drop", int'(ifa.match), 0);

    // T5: asynchronous reset in the middle of a pattern
    drive_ab(0, 0, 1, 4'b1011, 1); tick();
    drive_ab(1, 1, 0, 0, 0); tick();
    drive_ab(1, 0, 0, 0, 0); tick();
    drive_ab(1, 1, 0, 0, 0); tick();
    chk("t5_pre", int'(ifa.progress), 3);
    drive_ab(0, 0, 0, 0, 0);
    #3 RST = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_prog",  int'(ifa.progress), 0);
    chk("t5_rst_match", int'(ifa.match), 0);
    chk("t5_rst_prog_b", int'(ifb.progress), 0);
    #2 RST = 1'b1;
    drive_ab(0, 0, 1, 4'b1011, 0); tick();
    drive_ab(1, 1, 0, 0, 0); tick();
    chk("t5_post_prog",  int'(ifa.progress), 1);
    chk("t5_post_match", int'(ifa.match), 0);
    drive_ab(0, 0, 0, 0, 0);

    // T6: two-bit counter saturation and clear-wins-over-accept
    drive_c(0, 0, 1, 2'b01, 1); tick();
    for (int r = 0; r < 5; r++) begin
      drive_c(1, 0, 0, 0, 0); tick();
      drive_c(1, 1, 0, 0, 0); tick();
      chk("t6_cnt",   int'(ifc.match_cnt), t6_cnt[r]);
      chk("t6_match", int'(ifc.match), 1);
    end
    drive_c(1, 0, 0, 0, 0); tick();
    chk("t6_match_low", int'(ifc.match), 0);
    drive_c(1, 1, 0, 0, 1); tick();
    chk("t6_clr_cnt",   int'(ifc.match_cnt), 0);
    chk("t6_clr_match", int'(ifc.match), 1);
    drive_c(0, 0, 0, 0, 0);

    // All-zero pattern is an ordinary pattern
    drive_ab(0, 0, 1, 0, 1); tick();
    for (int i = 0; i < 4; i++) begin
      drive_ab(1, 0, 0, 0, 0); tick();
    end
    chk("zero_match_a", int'(ifa.match), 1);
    chk("zero_match_b", int'(ifb.match), 1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      drive_ab(int'($urandom_range(0, 3) != 0), $urandom_range(0, 1),
               int'($urandom_range(0, 39) == 0), $urandom_range(0, 15),
               int'($urandom_range(0, 49) == 0));
      drive_c(int'($urandom_range(0, 3) != 0), $urandom_range(0, 1),
              int'($urandom_range(0, 39) == 0), $urandom_range(0, 3),
              int'($urandom_range(0, 49) == 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
